// File: rtl/fu_pipe_unit.sv
// DySER fabric functional unit: per-direction operand FIFOs, credit-gated issue,
// and a LAT-deep valid-tracked result pipeline driving the SE output.
module fu_pipe_unit #(
  parameter int ID          = 0,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2,
  parameter int LAT         = 4,
  parameter int OUT_CREDITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       conf,
  input  logic [DATA_W+1:0] d_in_NW,
  input  logic [DATA_W+1:0] d_in_NE,
  input  logic [DATA_W+1:0] d_in_SE,
  input  logic [DATA_W+1:0] d_in_SW,
  input  logic              c_in_SE,
  output logic              c_out_NW,
  output logic              c_out_NE,
  output logic              c_out_SE,
  output logic              c_out_SW,
  output logic [DATA_W+1:0] d_out_SE,
  output logic              busy,
  output logic              err
);
  localparam int TW  = DATA_W + 2;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW  = $clog2(OUT_CREDITS + 1);
  localparam int SHW = $clog2(DATA_W);

  logic [3:0] func;
  logic       const_en;
  logic [3:0] cnst;
  logic [1:0] r_sel, l_sel, p_sel;
  logic       p_inv;
  assign {func, const_en, cnst, r_sel, l_sel, p_sel, p_inv} = conf;

  // Direction index equals the direction code: SW=0 NW=1 NE=2 SE=3.
  logic [TW-1:0]   d_in [4];
  logic [DATA_W:0] head [4];   // {data, meta}
  logic [3:0]      used, nonempty, pop, push_ovf;
  logic            fire, credit_ovf;
  logic [KW-1:0]   credits;

  assign d_in[0] = d_in_SW;
  assign d_in[1] = d_in_NW;
  assign d_in[2] = d_in_NE;
  assign d_in[3] = d_in_SE;

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    logic [DATA_W:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic            push;

    // A full FIFO still accepts when the same cycle pops it.
    assign push        = d_in[g][0] && ((cnt != CW'(DEPTH)) || pop[g]);
    assign push_ovf[g] = d_in[g][0] && !push;
    assign nonempty[g] = (cnt != '0);
    assign head[g]     = mem[rd_ptr];
    assign used[g]     = (l_sel == 2'(g)) || (p_sel == 2'(g)) || (!const_en && (r_sel == 2'(g)));

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= d_in[g][TW-1:1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)   wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop[g]) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        case ({push, pop[g]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Flow control: a result may only be issued while a downstream credit is held; the
  // credit is consumed at fire so the pipeline never stalls. Each popped entry is
  // returned upstream as a one-cycle c_out pulse in the fire cycle.
  assign fire = (&(~used | nonempty)) && (credits != '0);
  assign pop  = fire ? used : 4'b0000;
  assign {c_out_SE, c_out_NE, c_out_NW, c_out_SW} = pop;

  logic [DATA_W-1:0] op_l, op_r, cst_ext, res;
  logic              pred;

  assign cst_ext = {{(DATA_W-4){cnst[3]}}, cnst};
  assign op_l    = head[l_sel][DATA_W:1];
  assign op_r    = const_en ? cst_ext : head[r_sel][DATA_W:1];
  assign pred    = head[p_sel][0] ^ p_inv;

  always_comb begin
    res = '0;
    case (func)
      4'd0:    res = op_l + op_r;
      4'd1:    res = op_l - op_r;
      4'd2:    res = op_l * op_r;
      4'd3:    res = op_l & op_r;
      4'd4:    res = op_l | op_r;
      4'd5:    res = op_l ^ op_r;
      4'd6:    res = op_l << op_r[SHW-1:0];
      4'd7:    res = op_l >> op_r[SHW-1:0];
      4'd8:    res = {{(DATA_W-1){1'b0}}, ($signed(op_l) < $signed(op_r))};
      4'd9:    res = {{(DATA_W-1){1'b0}}, (op_l == op_r)};
      4'd10:   res = pred ? op_l : op_r;
      4'd11:   res = op_l;
      default: res = '0;
    endcase
  end

  assign credit_ovf = c_in_SE && !fire && (credits == KW'(OUT_CREDITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= KW'(OUT_CREDITS);
      err     <= 1'b0;
    end else begin
      if (c_in_SE && !fire && !credit_ovf) credits <= credits + 1'b1;
      else if (fire && !c_in_SE)           credits <= credits - 1'b1;
      if (credit_ovf || (|push_ovf)) err <= 1'b1;
    end
  end

  logic [LAT-1:0]  pv;
  logic [DATA_W:0] pd [LAT];   // {result, predicate}, zero when the stage is empty

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= fire;
      pd[0] <= fire ? {res, pred} : '0;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign d_out_SE = {pd[LAT-1], pv[LAT-1]};
  assign busy     = (|nonempty) || (|pv);
endmodule

// File: tb/tb_fu_pipe_unit.sv
// Directed bench for fu_pipe_unit: expected results are queued at stimulus time and
// checked against every output token; flow-control and error behaviour checked inline.
module tb_fu_pipe_unit;
  localparam int DATA_W = 32, DEPTH = 2, LAT = 4, OUT_CREDITS = 2, TW = DATA_W + 2;
  localparam logic [1:0] SW = 2'd0, NW = 2'd1, NE = 2'd2;

  logic          clk = 1'b0, rst = 1'b0, c_in = 1'b0;
  logic [15:0]   conf = '0;
  logic [TW-1:0] d_nw = '0, d_ne = '0, d_se = '0, d_sw = '0;
  logic          c_out_nw, c_out_ne, c_out_se, c_out_sw, busy, err;
  logic [TW-1:0] d_out;

  int n_cmp = 0, n_bad = 0, out_cnt = 0, base = 0;
  logic [DATA_W:0] exp_q[$];   // {data, meta}
  logic [DATA_W:0] e;

  fu_pipe_unit #(.ID(0), .DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT), .OUT_CREDITS(OUT_CREDITS)) dut (
    .clk(clk), .rst(rst), .conf(conf),
    .d_in_NW(d_nw), .d_in_NE(d_ne), .d_in_SE(d_se), .d_in_SW(d_sw),
    .c_in_SE(c_in),
    .c_out_NW(c_out_nw), .c_out_NE(c_out_ne), .c_out_SE(c_out_se), .c_out_SW(c_out_sw),
    .d_out_SE(d_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [TW-1:0] tok(input logic meta, input logic [DATA_W-1:0] d);
    return {d, meta, 1'b1};
  endfunction

  function automatic logic [15:0] mk_conf(input logic [3:0] f, input logic ce, input logic [3:0] k,
                                          input logic [1:0] r, input logic [1:0] l,
                                          input logic [1:0] p, input logic pi);
    return {f, ce, k, r, l, p, pi};
  endfunction

  function automatic logic [DATA_W-1:0] model(input logic [3:0] f, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input logic p);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a == b) ? 32'd1 : 32'd0;
      4'd10:   return p ? a : b;
      4'd11:   return a;
      default: return 32'd0;
    endcase
  endfunction

  // Output monitor: every valid token must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (d_out[0]) begin
        out_cnt++;
        if (exp_q.size() == 0) check("unexpected_out", d_out, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("out_token", d_out, {e, 1'b1});
        end
      end else begin
        check("idle_out_zero", d_out, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    d_nw = '0; d_ne = '0; d_se = '0; d_sw = '0; c_in = 1'b0;
  endtask

  task automatic give_credits(input int n);
    for (int i = 0; i < n; i++) begin
      c_in = 1'b1;
      step();
      c_in = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (busy || exp_q.size() != 0); k++) step();
    check("drain_busy", busy, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic send_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic m);
    d_nw = tok(1'b0, a); d_ne = tok(1'b0, b); d_sw = tok(m, '0);
    exp_q.push_back({a + b, m});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] a, b;
    logic m, pi;

    // Reset state
    step(); step();
    check("rst_dout", d_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cout", {c_out_nw, c_out_ne, c_out_se, c_out_sw}, 0);
    rst = 1'b1;
    step();

    // Basic ADD, exact latency and credit pulses
    conf = mk_conf(4'd0, 1'b0, 4'd0, NE, NW, SW, 1'b0);
    d_nw = tok(1'b0, 32'd5); d_ne = tok(1'b0, 32'd7); d_sw = tok(1'b1, 32'd0);
    exp_q.push_back({32'd12, 1'b1});
    step(); idle_in();
    check("fire_cout", {c_out_nw, c_out_ne, c_out_se, c_out_sw}, 4'b1101);
    check("fire_busy", busy, 1);
    for (int i = 1; i < LAT; i++) begin
      step();
      check("lat_wait", d_out[0], 0);
      if (i == 1) check("cout_single", {c_out_nw, c_out_ne, c_out_se, c_out_sw}, 4'b0000);
    end
    step();
    check("lat_out", d_out, {32'd12, 1'b1, 1'b1});
    drain(); give_credits(1);

    // Constant operand: -2 + 10 = 8, NE not consumed
    conf = mk_conf(4'd0, 1'b1, 4'b1110, NE, NW, SW, 1'b0);
    d_nw = tok(1'b0, 32'd10); d_sw = tok(1'b0, 32'd0);
    exp_q.push_back({32'd8, 1'b0});
    step(); idle_in();
    check("const_cout", {c_out_nw, c_out_ne, c_out_se, c_out_sw}, 4'b1001);
    drain(); give_credits(1);

    // Credit limit: three sets, only two issue until a credit returns
    conf = mk_conf(4'd0, 1'b0, 4'd0, NE, NW, SW, 1'b0);
    base = out_cnt;
    for (int i = 0; i < 3; i++) begin
      send_add(32'(10 + i), 32'(3 * i), i[0]);
      step();
    end
    idle_in();
    repeat (10) step();
    check("credit_limit_outs", out_cnt - base, 2);
    check("credit_limit_busy", busy, 1);
    check("credit_limit_nofire", c_out_nw, 0);
    c_in = 1'b1; step(); c_in = 1'b0;
    check("credit_return_fire", c_out_nw, 1);
    drain();
    check("credit_total_outs", out_cnt - base, 3);
    give_credits(2);

    // FIFO overflow without a pop drops the token and sets sticky err
    d_nw = tok(1'b0, 32'd1); step(); check("fill1_err", err, 0);
    d_nw = tok(1'b0, 32'd2); step(); check("fill2_err", err, 0);
    d_nw = tok(1'b0, 32'd3); step(); idle_in();
    check("ovf_err", err, 1);
    repeat (3) step();
    check("ovf_err_sticky", err, 1);
    rst = 1'b0; step();
    check("rst2_err", err, 0);
    check("rst2_busy", busy, 0);
    rst = 1'b1; step();

    // Full FIFO with a same-cycle pop accepts the token
    d_nw = tok(1'b0, 32'd1); step();
    d_nw = tok(1'b0, 32'd2); d_ne = tok(1'b0, 32'd100); d_sw = tok(1'b0, 32'd0);
    exp_q.push_back({32'd101, 1'b0});
    step();
    d_nw = tok(1'b0, 32'd3); d_ne = '0; d_sw = '0;
    check("full_pop_fire", c_out_nw, 1);
    step();
    check("full_pop_err", err, 0);
    d_nw = '0; d_ne = tok(1'b0, 32'd200); d_sw = tok(1'b1, 32'd0);
    exp_q.push_back({32'd202, 1'b1});
    step();
    d_ne = tok(1'b0, 32'd300); d_sw = tok(1'b0, 32'd0); c_in = 1'b1;
    exp_q.push_back({32'd303, 1'b0});
    step(); idle_in();
    drain();
    check("full_pop_err_end", err, 0);
    give_credits(2);

    // Same direction for L, R and P: one pop, SUB gives 0
    conf = mk_conf(4'd1, 1'b0, 4'd0, SW, SW, SW, 1'b0);
    d_sw = tok(1'b1, 32'd9);
    exp_q.push_back({32'd0, 1'b1});
    step(); idle_in();
    check("same_dir_cout", {c_out_nw, c_out_ne, c_out_se, c_out_sw}, 4'b0001);
    step();
    check("same_dir_single_pop", c_out_sw, 0);
    drain(); give_credits(1);

    // Signed LT: -1 < 1
    conf = mk_conf(4'd8, 1'b0, 4'd0, NE, NW, SW, 1'b0);
    d_nw = tok(1'b0, 32'hFFFF_FFFF); d_ne = tok(1'b0, 32'd1); d_sw = tok(1'b0, 32'd0);
    exp_q.push_back({32'd1, 1'b0});
    step(); idle_in();
    drain(); give_credits(1);

    // Every function code with random operands and predicate inversion
    for (int f = 0; f < 16; f++) begin
      a  = $urandom;
      b  = (f == 9 && $urandom_range(0, 1) == 1) ? a : $urandom;
      m  = 1'($urandom_range(0, 1));
      pi = 1'($urandom_range(0, 1));
      conf = mk_conf(4'(f), 1'b0, 4'd0, NE, NW, SW, pi);
      d_nw = tok(1'b0, a); d_ne = tok(1'b0, b); d_sw = tok(m, '0);
      exp_q.push_back({model(4'(f), a, b, m ^ pi), m ^ pi});
      step(); idle_in();
      drain(); give_credits(1);
    end

    // Reset two cycles after fire discards the in-flight result
    conf = mk_conf(4'd0, 1'b0, 4'd0, NE, NW, SW, 1'b0);
    d_nw = tok(1'b0, 32'd4); d_ne = tok(1'b0, 32'd5); d_sw = tok(1'b0, 32'd0);
    step(); idle_in();
    check("mid_rst_fire", c_out_nw, 1);
    step(); step();
    rst = 1'b0;
    step();
    check("mid_rst_dout", d_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cout", {c_out_nw, c_out_ne, c_out_se, c_out_sw}, 0);
    rst = 1'b1;
    base = out_cnt;
    repeat (8) step();
    check("mid_rst_no_out", out_cnt - base, 0);
    check("mid_rst_busy_after", busy, 0);

    // Credits restored to OUT_CREDITS after reset
    for (int i = 0; i < 3; i++) begin
      send_add(32'(50 + i), 32'(7 + i), ~i[0]);
      step();
    end
    idle_in();
    repeat (10) step();
    check("rst_credit_outs", out_cnt - base, 2);
    give_credits(1);
    drain();
    check("rst_credit_total", out_cnt - base, 3);
    give_credits(2);
    check("credit_full_err", err, 0);
    give_credits(1);
    check("credit_ovf_err", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
